// File: rtl/commit_trace_buffer.sv
// Commit-trace capture for the riscv_cpu retire stream: classifies, filters, sequence-tags
// and buffers retire records, then drains them to a valid/ready sink with loss accounting.
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [31:0]              instr_i,
    input  logic [4:0]               reg_addr_i,
    input  logic [XLEN-1:0]          reg_data_i,
    input  logic [XLEN-1:0]          mem_addr_i,
    input  logic [XLEN-1:0]          mem_data_i,
    input  logic                     stall_i,
    input  logic                     flushD_i,
    input  logic                     flushE_i,
    input  logic [2:0]               filter_i,
    input  logic                     clear_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [XLEN-1:0]          rec_pc_o,
    output logic [31:0]              rec_instr_o,
    output logic [4:0]               rec_rd_o,
    output logic [XLEN-1:0]          rec_data_o,
    output logic [XLEN-1:0]          rec_addr_o,
    output logic [1:0]               rec_kind_o,
    output logic [1:0]               rec_tag_o,
    output logic [SEQ_W-1:0]         rec_seq_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    typedef enum logic [1:0] {
        KIND_WB    = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_NOWB  = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        TAG_NORMAL = 2'd0,
        TAG_STALL  = 2'd1,
        TAG_FLUSH  = 2'd2
    } tag_t;

    // Classification of the current retire slot
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] store_mask;
    kind_t           cls_kind;
    tag_t            cls_tag;
    logic [4:0]      cls_rd;
    logic [XLEN-1:0] cls_data;
    logic [XLEN-1:0] cls_addr;
    logic            discard;
    logic            pass;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    always_comb begin
        store_mask = '1;
        case (funct3)
            3'b000:  store_mask = XLEN'(8'hFF);
            3'b001:  store_mask = XLEN'(16'hFFFF);
            3'b010:  store_mask = XLEN'(32'hFFFF_FFFF);
            default: store_mask = '1;
        endcase
    end

    always_comb begin
        cls_kind = KIND_NOWB;
        cls_tag  = TAG_NORMAL;
        cls_rd   = 5'd0;
        cls_data = '0;
        cls_addr = '0;
        if (opcode == OPC_STORE) begin
            cls_kind = KIND_STORE;
            cls_data = mem_data_i & store_mask;
            cls_addr = mem_addr_i;
        end else if (opcode == OPC_LOAD) begin
            cls_kind = KIND_LOAD;
            cls_rd   = reg_addr_i;
            cls_data = reg_data_i;
            cls_addr = mem_addr_i;
        end else begin
            if (reg_addr_i != 5'd0) begin
                cls_kind = KIND_WB;
                cls_rd   = reg_addr_i;
                cls_data = reg_data_i;
            end else begin
                cls_kind = KIND_NOWB;
            end
            // Memory ops are never tagged; stall outranks flush
            if (stall_i) begin
                cls_tag = TAG_STALL;
            end else if (flushD_i || flushE_i) begin
                cls_tag = TAG_FLUSH;
            end
        end
    end

    assign discard = ((cls_tag == TAG_STALL) && filter_i[0])
                   || ((cls_tag == TAG_FLUSH) && filter_i[1])
                   || ((cls_kind == KIND_NOWB) && (cls_tag == TAG_NORMAL) && filter_i[2]);
    assign pass    = en_i && !discard;

    // FIFO control
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign pop   = !empty && rec_ready_i;
    assign push  = pass && (!full || pop);
    assign drop  = pass && full && !pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            seq      <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
            // Full-FIFO drops still burn a sequence number so the sink sees the gap
            if (pass) begin
                seq <= seq + SEQ_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Record storage; stale contents are harmless because pointers restart on reset/clear
    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [31:0]      mem_instr [DEPTH];
    logic [4:0]       mem_rd    [DEPTH];
    logic [XLEN-1:0]  mem_data  [DEPTH];
    logic [XLEN-1:0]  mem_addr  [DEPTH];
    logic [1:0]       mem_kind  [DEPTH];
    logic [1:0]       mem_tag   [DEPTH];
    logic [SEQ_W-1:0] mem_seq   [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc_i;
            mem_instr[wr_ptr] <= instr_i;
            mem_rd[wr_ptr]    <= cls_rd;
            mem_data[wr_ptr]  <= cls_data;
            mem_addr[wr_ptr]  <= cls_addr;
            mem_kind[wr_ptr]  <= cls_kind;
            mem_tag[wr_ptr]   <= cls_tag;
            mem_seq[wr_ptr]   <= seq;
        end
    end

    // Head fields read as zero while empty
    assign rec_valid_o = !empty;
    assign rec_pc_o    = empty ? '0 : mem_pc[rd_ptr];
    assign rec_instr_o = empty ? '0 : mem_instr[rd_ptr];
    assign rec_rd_o    = empty ? '0 : mem_rd[rd_ptr];
    assign rec_data_o  = empty ? '0 : mem_data[rd_ptr];
    assign rec_addr_o  = empty ? '0 : mem_addr[rd_ptr];
    assign rec_kind_o  = empty ? '0 : mem_kind[rd_ptr];
    assign rec_tag_o   = empty ? '0 : mem_tag[rd_ptr];
    assign rec_seq_o   = empty ? '0 : mem_seq[rd_ptr];

    assign level_o    = level;
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;
    localparam int CNT_W = 3;
    localparam int CMAX  = 7;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [31:0] pc, instr, rdata, maddr, mdata;
    logic [4:0]  raddr;
    logic        stall, flush_d, flush_e;
    logic [2:0]  filter;
    logic        clear;
    logic        ready;

    logic        rec_valid;
    logic [31:0] rec_pc, rec_instr, rec_data, rec_addr;
    logic [4:0]  rec_rd;
    logic [1:0]  rec_kind, rec_tag;
    logic [15:0] rec_seq;
    logic [4:0]  level;
    logic [2:0]  drop_cnt;
    logic        overflow;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .pc_i(pc), .instr_i(instr),
        .reg_addr_i(raddr), .reg_data_i(rdata), .mem_addr_i(maddr), .mem_data_i(mdata),
        .stall_i(stall), .flushD_i(flush_d), .flushE_i(flush_e), .filter_i(filter),
        .clear_i(clear), .rec_valid_o(rec_valid), .rec_ready_i(ready),
        .rec_pc_o(rec_pc), .rec_instr_o(rec_instr), .rec_rd_o(rec_rd), .rec_data_o(rec_data),
        .rec_addr_o(rec_addr), .rec_kind_o(rec_kind), .rec_tag_o(rec_tag), .rec_seq_o(rec_seq),
        .level_o(level), .drop_cnt_o(drop_cnt), .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [1:0]  kind;
        logic [1:0]  tag;
        logic [15:0] seq;
    } rec_t;

    rec_t q[$];
    int   m_seq;
    int   m_drop;
    bit   m_ovf;
    int   n_checks;
    int   n_pass;
    bit   chk_on;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Record the retire slot should produce, straight from the classification rules
    function automatic rec_t classify(input logic [31:0] i_pc, i_instr, input logic [4:0] i_rd,
                                      input logic [31:0] i_rdata, i_maddr, i_mdata,
                                      input logic i_st, i_fd, i_fe);
        rec_t r;
        r = '0;
        r.pc = i_pc;
        r.instr = i_instr;
        if (i_instr[6:0] == 7'b0100011) begin
            r.kind = 2;
            r.addr = i_maddr;
            if (i_instr[14:12] == 3'd0)      r.data = {24'd0, i_mdata[7:0]};
            else if (i_instr[14:12] == 3'd1) r.data = {16'd0, i_mdata[15:0]};
            else                             r.data = i_mdata;
        end else if (i_instr[6:0] == 7'b0000011) begin
            r.kind = 1;
            r.rd = i_rd;
            r.data = i_rdata;
            r.addr = i_maddr;
        end else begin
            r.kind = (i_rd != 0) ? 2'd0 : 2'd3;
            r.rd = i_rd;
            r.data = (i_rd != 0) ? i_rdata : 32'd0;
            r.tag = i_st ? 2'd1 : ((i_fd || i_fe) ? 2'd2 : 2'd0);
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        rec_t r;
        bit   keep;
        bit   was_full;
        bit   popped;
        if (!rstn || clear) begin
            q.delete();
            m_seq = 0;
            m_drop = 0;
            m_ovf = 0;
        end else begin
            r = classify(pc, instr, raddr, rdata, maddr, mdata, stall, flush_d, flush_e);
            keep = en && !((r.tag == 1 && filter[0]) || (r.tag == 2 && filter[1]) ||
                           (r.kind == 3 && r.tag == 0 && filter[2]));
            was_full = (q.size() == DEPTH);
            popped = (q.size() > 0) && ready;
            if (popped) void'(q.pop_front());
            if (keep) begin
                r.seq = m_seq[15:0];
                m_seq = (m_seq + 1) % 65536;
                if (!was_full || popped) q.push_back(r);
                else begin
                    if (m_drop < CMAX) m_drop++;
                    m_ovf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        rec_t h;
        if (chk_on) begin
            h = (q.size() > 0) ? q[0] : '0;
            chk("valid", rec_valid, q.size() > 0);
            chk("level", level, q.size());
            chk("drop_cnt", drop_cnt, m_drop);
            chk("overflow", overflow, m_ovf);
            chk("pc", rec_pc, h.pc);
            chk("instr", rec_instr, h.instr);
            chk("rd", rec_rd, h.rd);
            chk("data", rec_data, h.data);
            chk("addr", rec_addr, h.addr);
            chk("kind", rec_kind, h.kind);
            chk("tag", rec_tag, h.tag);
            chk("seq", rec_seq, h.seq);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cap(input logic [31:0] c_pc, c_instr, input logic [4:0] c_rd,
                       input logic [31:0] c_rdata, c_maddr, c_mdata,
                       input logic c_st, c_fd, c_fe);
        pc = c_pc; instr = c_instr; raddr = c_rd; rdata = c_rdata;
        maddr = c_maddr; mdata = c_mdata; stall = c_st; flush_d = c_fd; flush_e = c_fe;
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; chk_on = 0;
        rstn = 0; en = 0; clear = 0; ready = 0; filter = 3'b000;
        pc = 0; instr = 0; raddr = 0; rdata = 0; maddr = 0; mdata = 0;
        stall = 0; flush_d = 0; flush_e = 0;

        // Reset and idle
        tick(); chk_on = 1; tick();
        chk("rst_valid", rec_valid, 0); chk("rst_level", level, 0);
        chk("rst_drop", drop_cnt, 0);   chk("rst_ovf", overflow, 0);
        rstn = 1; tick(); tick();
        chk("idle_valid", rec_valid, 0); chk("idle_level", level, 0);

        // Classification: sb, lw, addi x0
        cap(32'h1000, 32'h00A10023, 5'd7, 32'h11111111, 32'h100, 32'h12345678, 0, 0, 0);
        chk("lat_valid", rec_valid, 1);
        cap(32'h1004, 32'h0002A283, 5'd5, 32'hDEADBEEF, 32'h200, 32'h0, 0, 0, 0);
        cap(32'h1008, 32'h00000013, 5'd0, 32'h5555, 32'h300, 32'h0, 0, 0, 0);
        chk("cls_level", level, 3);
        chk("sb_kind", rec_kind, 2); chk("sb_data", rec_data, 32'h78);
        chk("sb_addr", rec_addr, 32'h100); chk("sb_rd", rec_rd, 0); chk("sb_seq", rec_seq, 0);
        ready = 1; tick();
        chk("lw_kind", rec_kind, 1); chk("lw_rd", rec_rd, 5);
        chk("lw_data", rec_data, 32'hDEADBEEF); chk("lw_seq", rec_seq, 1);
        tick();
        chk("nowb_kind", rec_kind, 3); chk("nowb_data", rec_data, 0);
        chk("nowb_addr", rec_addr, 0); chk("nowb_seq", rec_seq, 2);
        tick(); tick();
        chk("empty_level", level, 0); chk("empty_pc", rec_pc, 0);
        ready = 0;

        // Store width masking
        cap(32'h1100, 32'h00A11023, 5'd0, 32'h0, 32'h104, 32'hCAFEBABE, 0, 0, 0);
        cap(32'h1104, 32'h00A12023, 5'd0, 32'h0, 32'h108, 32'hCAFEBABE, 0, 0, 0);
        cap(32'h1108, 32'h00A13023, 5'd0, 32'h0, 32'h10C, 32'hCAFEBABE, 0, 0, 0);
        chk("sh_data", rec_data, 32'hBABE); chk("sh_seq", rec_seq, 3);
        ready = 1; tick();
        chk("sw_data", rec_data, 32'hCAFEBABE);
        tick(); tick(); ready = 0;

        // Tags and filters
        cap(32'h2000, 32'h00000193, 5'd3, 32'h77, 32'h0, 32'h0, 1, 0, 1);
        chk("stall_tag", rec_tag, 1); chk("stall_kind", rec_kind, 0); chk("stall_seq", rec_seq, 6);
        filter = 3'b001;
        cap(32'h2004, 32'h00000193, 5'd3, 32'h77, 32'h0, 32'h0, 1, 0, 1);
        chk("filt_stall_level", level, 1);
        filter = 3'b010;
        cap(32'h2008, 32'h00000193, 5'd3, 32'h78, 32'h0, 32'h0, 0, 1, 0);
        chk("filt_flush_level", level, 1);
        filter = 3'b100;
        cap(32'h200C, 32'h00000013, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        cap(32'h2010, 32'h00000013, 5'd0, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        filter = 3'b001;
        cap(32'h2014, 32'h0002A283, 5'd5, 32'h99, 32'h40, 32'h0, 1, 0, 0);
        filter = 3'b011;
        cap(32'h2018, 32'h00000193, 5'd3, 32'h1, 32'h0, 32'h0, 0, 1, 0);
        chk("filt_level", level, 3);
        filter = 3'b000;
        ready = 1; tick();
        chk("nowb_stall_seq", rec_seq, 7); chk("nowb_stall_tag", rec_tag, 1);
        tick();
        chk("ld_stall_tag", rec_tag, 0); chk("ld_stall_seq", rec_seq, 8);
        tick(); ready = 0;

        // Push and pop together at level 1
        cap(32'h3000, 32'h00100093, 5'd1, 32'hA, 32'h0, 32'h0, 0, 0, 0);
        ready = 1;
        cap(32'h3004, 32'h00100093, 5'd1, 32'hB, 32'h0, 32'h0, 0, 0, 0);
        chk("pp1_level", level, 1); chk("pp1_pc", rec_pc, 32'h3004); chk("pp1_seq", rec_seq, 10);
        tick(); ready = 0;

        // Overflow with drop counter saturation
        clear = 1; tick(); clear = 0;
        for (int i = 0; i < 20; i++)
            cap(32'h4000 + 4 * i, 32'h00100093, 5'd1, i, 32'h0, 32'h0, 0, 0, 0);
        chk("ovf_level", level, 16); chk("ovf_drop", drop_cnt, 4);
        chk("ovf_flag", overflow, 1); chk("ovf_head", rec_seq, 0);
        ready = 1;
        cap(32'h5000, 32'h00100093, 5'd1, 32'h50, 32'h0, 32'h0, 0, 0, 0);
        chk("fullpp_level", level, 16); chk("fullpp_drop", drop_cnt, 4); chk("fullpp_head", rec_seq, 1);
        ready = 0;
        for (int i = 0; i < 5; i++)
            cap(32'h6000 + 4 * i, 32'h00100093, 5'd1, i, 32'h0, 32'h0, 0, 0, 0);
        chk("sat_drop", drop_cnt, 7);
        ready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_seq", rec_seq, (k < 15) ? k + 1 : 20);
            tick();
        end
        chk("drained_valid", rec_valid, 0);
        ready = 0;
        cap(32'h7000, 32'h00100093, 5'd1, 32'h7, 32'h0, 32'h0, 0, 0, 0);
        chk("post_ovf_seq", rec_seq, 26);

        // Clear mid-drain, with a capture in the clearing cycle
        for (int i = 0; i < 4; i++)
            cap(32'h7100 + 4 * i, 32'h00100093, 5'd1, i, 32'h0, 32'h0, 0, 0, 0);
        chk("pre_clr_level", level, 5);
        ready = 1; clear = 1;
        cap(32'h7200, 32'h00100093, 5'd1, 32'h1, 32'h0, 32'h0, 0, 0, 0);
        clear = 0; ready = 0;
        chk("clr_level", level, 0); chk("clr_valid", rec_valid, 0);
        chk("clr_drop", drop_cnt, 0); chk("clr_ovf", overflow, 0);
        cap(32'h7300, 32'h00100093, 5'd1, 32'h2, 32'h0, 32'h0, 0, 0, 0);
        chk("clr_seq", rec_seq, 0);

        // Reset mid-transfer
        cap(32'h7304, 32'h00100093, 5'd1, 32'h3, 32'h0, 32'h0, 0, 0, 0);
        rstn = 0; ready = 1; tick(); rstn = 1; ready = 0;
        chk("rstm_level", level, 0);
        cap(32'h7400, 32'h00100093, 5'd1, 32'h4, 32'h0, 32'h0, 0, 0, 0);
        chk("rstm_seq", rec_seq, 0);
        tick();

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
